alu_issue: RTL and testbench

Initiator side of the ALU interface: accepts operation requests over a valid/ready handshake, drives `op`/`in1`/`in2`/`alu_enable` into the ALU, captures the registered ALU result one cycle later, and returns it with the request's tag through a response FIFO. It sits between the decode/execute control and the ALU. It sustains one operation per cycle while response space allows, and applies back-pressure through credit accounting.

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_if.sv | 35 +++
 rtl/alu_rsp_fifo.sv | 51 +++++
 rtl/alu_issue.sv | 81 ++++++++
 tb/tb_alu_issue.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared ALU datapath parameters, opcodes and the response payload type for alu_issue.
package alu_issue_pkg;

  localparam int unsigned WORD_SIZE           = 16;
  localparam int unsigned ALU_ISSUE_TAG_W_DEF = 4;
  localparam int unsigned TAG_W               = ALU_ISSUE_TAG_W_DEF;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_MUL   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_SLT   = 3'd6,
    ALU_SHIFT = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic [TAG_W-1:0]     tag;
  } rsp_t;

endpackage

// File: rtl/alu_issue_if.sv
// Request, ALU-drive and response signals of alu_issue; slave is the issue block, master its environment.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [WORD_SIZE-1:0] req_a;
  logic [WORD_SIZE-1:0] req_b;
  logic [TAG_W-1:0]     req_tag;
  logic                 req_fwd;

  logic [2:0]           alu_op;
  logic [WORD_SIZE-1:0] alu_in1;
  logic [WORD_SIZE-1:0] alu_in2;
  logic                 alu_enable;
  logic [WORD_SIZE-1:0] alu_out;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WORD_SIZE-1:0] rsp_data;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, req_fwd, alu_out, rsp_ready,
    output req_ready, alu_op, alu_in1, alu_in2, alu_enable, rsp_valid, rsp_data, rsp_tag, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, req_fwd, alu_out, rsp_ready,
    input  req_ready, alu_op, alu_in1, alu_in2, alu_enable, rsp_valid, rsp_data, rsp_tag, busy
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO (result + tag) with occupancy count; DEPTH must be a power of two.
module alu_rsp_fifo
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  rsp_t                   i_data,
  input  logic                   i_pop,
  output rsp_t                   o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rsp_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_issue.sv
// ALU issue/initiator: handshakes requests into the ALU and returns tagged results in order.
// Optional operand forwarding of the previous result is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic             r_inflight_v;
  logic [TAG_W-1:0] r_inflight_tag;
  logic [CNT_W-1:0] w_count;
  logic [OCC_W-1:0] w_occ;
  logic             w_issue;
  logic             w_rsp_valid;
  logic             w_pop;
  rsp_t             w_push_data;
  rsp_t             w_head;

  // Credits cover both the FIFO and the op whose result is still in the ALU.
  assign w_occ         = {1'b0, w_count} + OCC_W'(r_inflight_v);
  assign bus.req_ready = rst_n && (w_occ < OCC_W'(DEPTH));
  assign w_issue       = bus.req_valid && bus.req_ready;

  assign bus.alu_enable = w_issue;
  assign bus.alu_op     = bus.req_op;
  assign bus.alu_in2    = bus.req_b;

`ifdef ALU_ISSUE_FWD_EN
  logic r_has_result;

  always_ff @(posedge clk) begin
    if (!rst_n)       r_has_result <= 1'b0;
    else if (w_issue) r_has_result <= 1'b1;
  end

  assign bus.alu_in1 = !bus.req_fwd  ? bus.req_a   :
                       r_has_result  ? bus.alu_out : '0;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = bus.req_fwd;
  assign bus.alu_in1  = bus.req_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight_v <= 1'b0;
    end else begin
      r_inflight_v <= w_issue;
      if (w_issue) r_inflight_tag <= bus.req_tag;
    end
  end

  assign w_push_data = '{data: bus.alu_out, tag: r_inflight_tag};
  assign w_rsp_valid = (w_count != '0);
  assign w_pop       = w_rsp_valid && bus.rsp_ready;

  alu_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight_v),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_head.data;
  assign bus.rsp_tag   = w_head.tag;
  assign bus.busy      = r_inflight_v || w_rsp_valid;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue with a behavioural ALU and an in-order response model.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = WORD_SIZE;

  typedef struct {
    logic [W-1:0]     d;
    logic [TAG_W-1:0] t;
    longint           c;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_if bus();

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_rsp = 0;
  int unsigned n_acc = 0;
  bit          last_acc;
  exp_t        exp_q[$];
  logic [W-1:0] m_last;
  bit          m_has;

  function automatic logic [W-1:0] ref_alu(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_MUL:   return a * b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default:   return a << b[3:0];
    endcase
  endfunction

  // Behavioural ALU: registers its result on the issue edge.
  always @(posedge clk) begin
    if (bus.alu_enable) bus.alu_out <= ref_alu(bus.alu_op, bus.alu_in1, bus.alu_in2);
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: what the accepted request should eventually return.
  task automatic model_accept();
    logic [W-1:0] in1;
    exp_t e;
    in1 = bus.req_a;
`ifdef ALU_ISSUE_FWD_EN
    if (bus.req_fwd) in1 = m_has ? m_last : '0;
`endif
    e.d = ref_alu(bus.req_op, in1, bus.req_b);
    e.t = bus.req_tag;
    e.c = cyc;
    m_last = e.d;
    m_has  = 1'b1;
    exp_q.push_back(e);
    n_acc++;
  endtask

  // One clock cycle: record acceptance mid-cycle, then check credit/valid/busy after the edge.
  task automatic tick();
    @(negedge clk);
    last_acc = rst_n && bus.req_valid && bus.req_ready;
    if (!rst_n) begin
      exp_q.delete();
      m_has = 1'b0;
    end
    if (last_acc) model_accept();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_busy",      32'(bus.busy),      0);
    end else begin
      check("req_ready", 32'(bus.req_ready), 32'(exp_q.size() < DEPTH));
      check("busy",      32'(bus.busy),      32'(exp_q.size() != 0));
      check("rsp_valid", 32'(bus.rsp_valid),
            32'((exp_q.size() != 0) && (cyc - exp_q[0].c >= 2)));
    end
  endtask

  task automatic drive(bit v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [TAG_W-1:0] t, bit f);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = t;
    bus.req_fwd   = f;
  endtask

  task automatic drive_rand();
    drive(1'b1, 3'($urandom), W'($urandom), W'($urandom), TAG_W'($urandom), 1'($urandom));
  endtask

  task automatic drain(int unsigned budget);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every response handshake pops the scoreboard and is compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got data %0h tag %0h, required no response", bus.rsp_data, bus.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(e.d));
        check("rsp_tag",  32'(bus.rsp_tag),  32'(e.t));
      end
    end
    if (rst_n && dut.r_inflight_v && (dut.w_count == DEPTH)) begin
      n_vec++;
      n_err++;
      $display("FAIL push_while_full: count %0d required below %0d", dut.w_count, DEPTH);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc0;
    int unsigned rsp0;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 3'(ALU_ADD), '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 32'(bus.req_ready), 1);

    // Single ADD: 5 + 7, tag 3, response two cycles after acceptance.
    bus.rsp_ready = 1'b1;
    drive(1'b1, 3'(ALU_ADD), W'(5), W'(7), TAG_W'(3), 1'b0);
    #1;
    check("single_enable", 32'(bus.alu_enable), 1);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("single_enable_off", 32'(bus.alu_enable), 0);
    check("single_n1_valid",   32'(bus.rsp_valid),  0);
    tick();
    check("single_n2_valid", 32'(bus.rsp_valid), 1);
    check("single_data",     32'(bus.rsp_data),  12);
    check("single_tag",      32'(bus.rsp_tag),   3);
    drain(10);

    // Back-to-back SUBs with the response side always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(ALU_SUB), W'(10), W'(i), TAG_W'(i), 1'b0);
      tick();
      check("b2b_accept", 32'(last_acc), 1);
    end
    drain(10);

    // Back-pressure: only DEPTH requests fit with the response side stalled.
    bus.rsp_ready = 1'b0;
    acc0 = n_acc;
    drive_rand();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_acc) drive_rand();
    end
    check("bp_accepts",    n_acc - acc0, DEPTH);
    check("bp_ready_low",  32'(bus.req_ready), 0);
    drain(12);
    check("bp_ready_back", 32'(bus.req_ready), 1);

    // Reset with three ops buffered: nothing from them may come out.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    do_reset();
    check("midrst_busy",      32'(bus.busy),      0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    rsp0 = n_rsp;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_stale", n_rsp - rsp0, 0);

`ifdef ALU_ISSUE_FWD_EN
    // Forward before any issue reads zero; then chained ADD -> MUL.
    do_reset();
    drive(1'b1, 3'(ALU_OR), W'($urandom), W'(9), TAG_W'(1), 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("fwd_first_data", 32'(bus.rsp_data), 9);
    drive(1'b1, 3'(ALU_ADD), W'(2), W'(3), TAG_W'(2), 1'b0);
    tick();
    drive(1'b1, 3'(ALU_MUL), W'($urandom), W'(4), TAG_W'(3), 1'b1);
    tick();
    bus.req_valid = 1'b0;
    check("fwd_add_data", 32'(bus.rsp_data), 5);
    tick();
    check("fwd_mul_data", 32'(bus.rsp_data), 20);
    drain(10);
`endif

    // Randomized traffic with random response back-pressure.
    bus.req_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.req_valid || last_acc) begin
        drive_rand();
        bus.req_valid = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
